// File: rtl/viterbi_controller.sv
// Frame sequencer for the 802.11a Viterbi decoder: pairs coded bits into ACS steps,
// triggers traceback, and guards the datapath handshakes with a watchdog.
module viterbi_controller #(
  parameter int MAX_STEPS = 192,
  parameter int TIMEOUT   = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] StepCount,
  input  logic       Abort,
  input  logic       InBit,
  input  logic       InValid,
  output logic       InReady,
  output logic       ClearMetrics,
  output logic       AcsStart,
  output logic [1:0] AcsPair,
  output logic [9:0] AcsIndex,
  input  logic       AcsDone,
  output logic       TbStart,
  input  logic       TbDone,
  output logic       Busy,
  output logic       Done,
  output logic       Error
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, INIT, COLLECT0, COLLECT1, ACS_ISSUE, ACS_WAIT, TB_ISSUE, TB_WAIT, DONE
  } state_t;

  state_t         state, nxt;
  logic [9:0]     steps, idx;
  logic           first_bit;
  logic [WDW-1:0] wd_cnt;
  logic           wd_last, len_ok, err_nxt;

  assign wd_last = (wd_cnt == WDW'(TIMEOUT - 1));
  assign len_ok  = (StepCount != 10'd0) && (StepCount <= 10'(MAX_STEPS));

  always_comb begin
    nxt     = state;
    err_nxt = 1'b0;
    case (state)
      IDLE:      if (Start) begin
                   if (len_ok) nxt = INIT;
                   else        err_nxt = 1'b1;
                 end
      INIT:      nxt = COLLECT0;
      COLLECT0:  if (InValid && InReady) nxt = COLLECT1;
      COLLECT1:  if (InValid && InReady) nxt = ACS_ISSUE;
      ACS_ISSUE: nxt = ACS_WAIT;
      ACS_WAIT:  if (AcsDone) nxt = (idx == steps - 10'd1) ? TB_ISSUE : COLLECT0;
                 else if (wd_last) begin
                   nxt     = IDLE;
                   err_nxt = 1'b1;
                 end
      TB_ISSUE:  nxt = TB_WAIT;
      TB_WAIT:   if (TbDone) nxt = DONE;
                 else if (wd_last) begin
                   nxt     = IDLE;
                   err_nxt = 1'b1;
                 end
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    // Abort overrides everything, including a pending timeout or completion
    if (Abort && state != IDLE) begin
      nxt     = IDLE;
      err_nxt = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      steps        <= '0;
      idx          <= '0;
      first_bit    <= 1'b0;
      wd_cnt       <= '0;
      InReady      <= 1'b0;
      ClearMetrics <= 1'b0;
      AcsStart     <= 1'b0;
      AcsPair      <= '0;
      AcsIndex     <= '0;
      TbStart      <= 1'b0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= nxt;
      Busy         <= (nxt != IDLE);
      InReady      <= (nxt == COLLECT0) || (nxt == COLLECT1);
      ClearMetrics <= (nxt == INIT);
      AcsStart     <= (nxt == ACS_ISSUE);
      TbStart      <= (nxt == TB_ISSUE);
      Done         <= (nxt == DONE);
      Error        <= err_nxt;

      if (state == IDLE && nxt == INIT) steps <= StepCount;
      if (state == INIT) idx <= '0;
      if (state == ACS_WAIT && nxt == COLLECT0) idx <= idx + 10'd1;
      if (state == COLLECT0 && nxt == COLLECT1) first_bit <= InBit;
      if (state == COLLECT1 && nxt == ACS_ISSUE) begin
        AcsPair  <= {first_bit, InBit};
        AcsIndex <= idx;
      end

      if (nxt != state && (nxt == ACS_WAIT || nxt == TB_WAIT))
        wd_cnt <= '0;
      else if ((state == ACS_WAIT && !AcsDone) || (state == TB_WAIT && !TbDone))
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_viterbi_controller.sv
// Directed bench for viterbi_controller: a datapath responder, an ACS scoreboard,
// and a linear sequence of frame scenarios.
module tb_viterbi_controller;
  localparam int MAX_STEPS = 192;
  localparam int TIMEOUT   = 64;

  logic       Clock = 0, Reset = 1, Start = 0, Abort = 0, InBit = 0, InValid = 0;
  logic [9:0] StepCount = '0;
  logic       acs_done_r = 0, tb_done_r = 0, spur_acs = 0, spur_tb = 0;
  logic       InReady, ClearMetrics, AcsStart, TbStart, Busy, Done, Error;
  logic [1:0] AcsPair;
  logic [9:0] AcsIndex;

  int checks = 0, errors = 0;
  logic [11:0] sb[$];
  int acs_lat = 2, tb_lat = 5, acs_tmr = 0, tb_tmr = 0;
  int n_clear = 0, n_acs = 0, n_tb = 0, n_done = 0, n_err = 0, last_idx = -1;
  int s_clear, s_acs, s_tb, s_done, s_err;

  viterbi_controller #(.MAX_STEPS(MAX_STEPS), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .StepCount(StepCount), .Abort(Abort),
    .InBit(InBit), .InValid(InValid), .InReady(InReady), .ClearMetrics(ClearMetrics),
    .AcsStart(AcsStart), .AcsPair(AcsPair), .AcsIndex(AcsIndex),
    .AcsDone(acs_done_r | spur_acs), .TbStart(TbStart), .TbDone(tb_done_r | spur_tb),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Datapath responder and ACS scoreboard, sampled on the falling edge
  initial forever begin
    @(negedge Clock);
    acs_done_r = 0;
    tb_done_r  = 0;
    if (acs_tmr > 0) begin acs_tmr--; if (acs_tmr == 0) acs_done_r = 1; end
    if (tb_tmr > 0)  begin tb_tmr--;  if (tb_tmr == 0)  tb_done_r  = 1; end
    if (AcsStart === 1'b1) begin
      n_acs++;
      last_idx = AcsIndex;
      if (acs_lat > 0) acs_tmr = acs_lat;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL acs_unexpected: observed index %0d expected no AcsStart", AcsIndex);
      end
      if (sb.size() != 0) chk("acs_pair_idx", {AcsPair, AcsIndex}, sb.pop_front());
    end
    if (TbStart === 1'b1) begin n_tb++; tb_tmr = tb_lat; end
    if (ClearMetrics === 1'b1) n_clear++;
    if (Done === 1'b1) n_done++;
    if (Error === 1'b1) n_err++;
  end

  task automatic snap();
    s_clear = n_clear; s_acs = n_acs; s_tb = n_tb; s_done = n_done; s_err = n_err;
  endtask

  task automatic chk_counts(input string tag, input int acs, input int tb, input int dn, input int er);
    chk({tag, "_acs"},  n_acs - s_acs, acs);
    chk({tag, "_tb"},   n_tb - s_tb, tb);
    chk({tag, "_done"}, n_done - s_done, dn);
    chk({tag, "_err"},  n_err - s_err, er);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n = 0;
    if (gap) begin
      InValid = 0; InBit = ~b;
      if (InReady) begin
        @(negedge Clock);
        chk("inready_gap", InReady, 1);
      end else @(negedge Clock);
    end
    InValid = 1; InBit = b;
    while (!InReady && n < 300) begin @(negedge Clock); n++; end
    chk("inready_wait", InReady, 1);
    @(negedge Clock);
    InValid = 0;
  endtask

  task automatic send_pair(input logic b0, input logic b1, input logic [9:0] idx, input bit gap);
    sb.push_back({b0, b1, idx});
    send_bit(b0, gap);
    send_bit(b1, gap);
  endtask

  task automatic start_frame(input logic [9:0] n);
    Start = 1; StepCount = n;
    @(negedge Clock);
    Start = 0;
    chk("clear_t1", ClearMetrics, 1);
    chk("busy_t1", Busy, 1);
    @(negedge Clock);
    chk("inready_t2", InReady, 1);
  endtask

  task automatic finish_frame();
    int n = 0;
    while (!Done && n < 400) begin @(negedge Clock); n++; end
    chk("done_seen", Done, 1);
    chk("busy_at_done", Busy, 1);
    @(negedge Clock);
    chk("busy_after_done", Busy, 0);
    chk("done_one_cycle", Done, 0);
  endtask

  task automatic short_frame(input bit gap);
    start_frame(3);
    send_pair(1, 1, 0, gap);
    send_pair(0, 1, 1, gap);
    send_pair(1, 0, 2, gap);
    finish_frame();
  endtask

  initial begin
    int n;
    logic [9:0] bad [3] = '{10'd0, 10'd193, 10'd1023};

    repeat (2) @(negedge Clock);
    chk("reset_outputs", {InReady, ClearMetrics, AcsStart, AcsPair, AcsIndex, TbStart, Busy, Done, Error}, 0);
    Reset = 0;
    @(negedge Clock);
    chk("idle_outputs", {InReady, ClearMetrics, AcsStart, TbStart, Busy, Done, Error}, 0);

    // Normal frame, then the same frame with input gaps
    snap(); short_frame(0);
    chk("normal_clear", n_clear - s_clear, 1);
    chk_counts("normal", 3, 1, 1, 0);
    snap(); short_frame(1);
    chk_counts("gaps", 3, 1, 1, 0);

    // Length rejection
    foreach (bad[i]) begin
      snap();
      Start = 1; StepCount = bad[i];
      @(negedge Clock);
      Start = 0;
      chk("badlen_error", Error, 1);
      chk("badlen_busy", Busy, 0);
      chk("badlen_clear", ClearMetrics, 0);
      @(negedge Clock);
      chk("badlen_error_pulse", Error, 0);
      chk("badlen_noclear", n_clear - s_clear, 0);
    end

    // Maximum-length frame with the fastest datapath
    snap(); acs_lat = 1;
    start_frame(10'(MAX_STEPS));
    send_pair(1, 0, 0, 0);
    chk("acsstart_c1", AcsStart, 1);
    @(negedge Clock);
    chk("inready_wait_cycle", InReady, 0);
    @(negedge Clock);
    chk("inready_after_acsdone", InReady, 1);
    for (int i = 1; i < MAX_STEPS; i++)
      send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 10'(i), 0);
    finish_frame();
    chk("max_last_idx", last_idx, MAX_STEPS - 1);
    chk_counts("max", MAX_STEPS, 1, 1, 0);
    acs_lat = 2;

    // Watchdog expiry: no AcsDone at all
    snap(); acs_lat = 0;
    start_frame(3);
    send_pair(1, 0, 0, 0);
    chk("wd_acsstart", AcsStart, 1);
    n = 0;
    while (!Error && n < 200) begin @(negedge Clock); n++; end
    chk("wd_error_cycle", n, TIMEOUT + 1);
    chk("wd_busy", Busy, 0);
    @(negedge Clock);
    acs_lat = 2;
    chk_counts("wd", 1, 0, 0, 1);

    // AcsDone in the last legal wait cycle wins over the timeout
    snap(); acs_lat = TIMEOUT;
    start_frame(3);
    send_pair(0, 0, 0, 0);
    @(negedge Clock);
    acs_lat = 2;
    send_pair(1, 1, 1, 0);
    send_pair(0, 1, 2, 0);
    finish_frame();
    chk_counts("wd_late", 3, 1, 1, 0);

    // Abort in COLLECT1 of step 1
    snap();
    start_frame(3);
    send_pair(0, 0, 0, 0);
    send_bit(1, 0);
    chk("abort_in_collect1", InReady, 1);
    Abort = 1;
    @(negedge Clock);
    Abort = 0;
    chk("abort_busy", Busy, 0);
    chk("abort_inready", InReady, 0);
    InValid = 1; InBit = 1;
    repeat (10) @(negedge Clock);
    InValid = 0;
    chk_counts("abort", 1, 0, 0, 0);

    // Reset during TB_WAIT, then a clean frame
    snap(); tb_lat = 20;
    start_frame(3);
    send_pair(1, 1, 0, 0);
    send_pair(1, 0, 1, 0);
    send_pair(0, 1, 2, 0);
    n = 0;
    while (!TbStart && n < 100) begin @(negedge Clock); n++; end
    chk("tbstart_seen", TbStart, 1);
    @(negedge Clock);
    Reset = 1;
    @(negedge Clock);
    chk("reset_tbwait_outputs", {InReady, ClearMetrics, AcsStart, AcsPair, AcsIndex, TbStart, Busy, Done, Error}, 0);
    Reset = 0;
    repeat (25) @(negedge Clock);
    tb_lat = 5;
    chk_counts("reset_frame", 3, 1, 0, 0);
    snap(); short_frame(0);
    chk_counts("post_reset", 3, 1, 1, 0);

    // Spurious Start / TbDone during ACS_WAIT and AcsDone during COLLECT0
    snap(); acs_lat = 3;
    start_frame(3);
    send_pair(1, 1, 0, 0);
    @(negedge Clock);
    Start = 1; StepCount = 10'd5; spur_tb = 1;
    @(negedge Clock);
    Start = 0; spur_tb = 0;
    chk("spur_busy", Busy, 1);
    chk("spur_noclear", ClearMetrics, 0);
    n = 0;
    while (!InReady && n < 50) begin @(negedge Clock); n++; end
    chk("spur_collect0", InReady, 1);
    spur_acs = 1;
    @(negedge Clock);
    spur_acs = 0;
    chk("spur_still_collect", InReady, 1);
    chk("spur_no_acsstart", AcsStart, 0);
    send_pair(0, 1, 1, 0);
    send_pair(1, 0, 2, 0);
    finish_frame();
    chk("spur_clear", n_clear - s_clear, 1);
    chk_counts("spur", 3, 1, 1, 0);
    acs_lat = 2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
